// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the multi-cycle mul/div unit.
// Optional remainder output is enabled with MULDIV_REM_EN.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic op_supported(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response handshake bundle for muldiv_seq.
// The rem signal exists only when MULDIV_REM_EN is defined.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             req_valid;
    logic             req_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] result;
`ifdef MULDIV_REM_EN
    logic [WIDTH-1:0] rem;
`endif

    modport master (
        output req_valid, op, src_a, src_b, res_ready,
`ifdef MULDIV_REM_EN
        input  rem,
`endif
        input  req_ready, res_valid, result
    );

    modport slave (
        input  req_valid, op, src_a, src_b, res_ready,
`ifdef MULDIV_REM_EN
        output rem,
`endif
        output req_ready, res_valid, result
    );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of shift-add multiply or
// restoring divide on a 2*WIDTH accumulator.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [3:0]         op_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               q_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH-1:0] diff;

    always_comb begin
        acc_o = acc_i;
        q_o   = 1'b0;
        sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
        shl   = acc_i[2*WIDTH-1:WIDTH-1];
        diff  = shl[WIDTH-1:0] - opnd_i;
        unique case (1'b1)
            (op_i == OP_MUL): begin
                // Carry out of the high half lands in the top bit.
                if (acc_i[0])
                    acc_o = {sum, acc_i[WIDTH-1:1]};
                else
                    acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
            end
            (op_i == OP_DIV): begin
                if (shl >= {1'b0, opnd_i}) begin
                    acc_o = {diff, acc_i[WIDTH-2:0], 1'b0};
                    q_o   = 1'b1;
                end else begin
                    acc_o = {shl[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: 32-iteration sequencer for ALU multiply and divide.
// Define MULDIV_REM_EN to expose the remainder / high product half.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    muldiv_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    state_e             state_q;
    logic               rv_q;
    logic [CW-1:0]      cnt_q;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] step_acc;
    logic               step_q;
    logic [WIDTH-1:0]   result_q;
`ifdef MULDIV_REM_EN
    logic [WIDTH-1:0]   rem_q;
`endif

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op_i   (op_q),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc),
        .q_o    (step_q)
    );

    assign acc_d = {step_acc[2*WIDTH-1:1], step_acc[0] | step_q};

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.res_valid = rv_q;
    assign bus.result    = result_q;
`ifdef MULDIV_REM_EN
    assign bus.rem       = rem_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rv_q     <= 1'b0;
            cnt_q    <= '0;
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
`ifdef MULDIV_REM_EN
            rem_q    <= '0;
`endif
        end else if (flush) begin
            state_q <= S_IDLE;
            rv_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        op_q  <= bus.op;
                        cnt_q <= '0;
                        if (bus.op == OP_MUL) begin
                            acc_q   <= {{WIDTH{1'b0}}, bus.src_b};
                            opnd_q  <= bus.src_a;
                            state_q <= S_CALC;
                        end else if (bus.op == OP_DIV && bus.src_b != '0) begin
                            acc_q   <= {{WIDTH{1'b0}}, bus.src_a};
                            opnd_q  <= bus.src_b;
                            state_q <= S_CALC;
                        end else begin
                            result_q <= op_supported(bus.op) ? '1 : '0;
`ifdef MULDIV_REM_EN
                            rem_q    <= op_supported(bus.op) ? bus.src_a : '0;
`endif
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        result_q <= acc_d[WIDTH-1:0];
`ifdef MULDIV_REM_EN
                        rem_q    <= acc_d[2*WIDTH-1:WIDTH];
`endif
                        rv_q     <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Short-circuited results raise valid one edge later.
                    if (!rv_q) begin
                        rv_q <= 1'b1;
                    end else if (bus.res_ready) begin
                        rv_q    <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed scoreboard bench for muldiv_seq.
// Compares rem as well when MULDIV_REM_EN is defined.
module tb_muldiv_seq;

    localparam int W = 32;

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic [W-1:0] rem;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flush;
    int   tests;
    int   fails;
    exp_t sb[$];

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_seq #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever a result handshake is about to occur.
    always @(negedge clk) begin
        if (rst_n && !flush && bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got result %0h expected none",
                         bus.result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, 64'(bus.result), 64'(e.res));
`ifdef MULDIV_REM_EN
                check({e.name, "_rem"}, 64'(bus.rem), 64'(e.rem));
`endif
            end
        end
    end

    task automatic wait_idle(input string name);
        int ok;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            if (bus.req_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check({name, "_idle"}, 64'(ok), 64'd1);
    endtask

    // Issues a request at the next edge and measures edges until res_valid.
    task automatic issue(input string name, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic push, input logic [W-1:0] er,
                         input logic [W-1:0] erem, input int lat);
        int seen;
        wait_idle(name);
        bus.req_valid = 1'b1;
        bus.op        = op;
        bus.src_a     = a;
        bus.src_b     = b;
        if (push) begin
            exp_t e;
            e.name = name;
            e.res  = er;
            e.rem  = erem;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (lat > 0) begin
            seen = 0;
            for (int k = 1; k <= 40; k++) begin
                if (bus.res_valid) begin
                    seen = k;
                    break;
                end
                @(posedge clk);
                #1;
            end
            check({name, "_latency"}, 64'(seen), 64'(lat));
        end
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        bus.op        = 4'b0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_res_valid", 64'(bus.res_valid), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
`ifdef MULDIV_REM_EN
        check("rst_rem", 64'(bus.rem), 64'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency counts the accept edge as E0.
        issue("mul7x6", 4'b0100, 32'd7, 32'd6, 1, 32'd42, 32'd0, 33);
        issue("mulff2", 4'b0100, 32'hFFFFFFFF, 32'd2, 1,
              32'hFFFFFFFE, 32'h1, 33);
        issue("mulffff", 4'b0100, 32'hFFFFFFFF, 32'hFFFFFFFF, 1,
              32'h1, 32'hFFFFFFFE, 33);
        issue("div100_7", 4'b0011, 32'd100, 32'd7, 1, 32'd14, 32'd2, 33);
        issue("divff_1", 4'b0011, 32'hFFFFFFFF, 32'd1, 1,
              32'hFFFFFFFF, 32'd0, 33);
        issue("div5_0", 4'b0011, 32'd5, 32'd0, 1, 32'hFFFFFFFF, 32'd5, 2);
        issue("unsup", 4'b0000, 32'd5, 32'd3, 1, 32'd0, 32'd0, 2);

        // Flush mid-CALC: no result, back to idle at once.
        issue("mul3x3", 4'b0100, 32'd3, 32'd3, 0, '0, '0, 0);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_req_ready", 64'(bus.req_ready), 64'd1);
        begin
            int hits;
            hits = 0;
            for (int k = 0; k < 40; k++) begin
                if (bus.res_valid) hits++;
                @(posedge clk);
                #1;
            end
            check("flush_no_valid", 64'(hits), 64'd0);
        end
        issue("div9_3", 4'b0011, 32'd9, 32'd3, 1, 32'd3, 32'd0, 33);

        // Back-pressure: result must hold while res_ready is low.
        wait_idle("bp");
        bus.res_ready = 1'b0;
        issue("div1000_10", 4'b0011, 32'd1000, 32'd10, 1, 32'd100, 32'd0, 33);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 64'(bus.res_valid), 64'd1);
            check("bp_result", 64'(bus.result), 64'd100);
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_req_ready", 64'(bus.req_ready), 64'd1);
        check("bp_valid_low", 64'(bus.res_valid), 64'd0);

        // Async reset mid-CALC.
        issue("mul5x5", 4'b0100, 32'd5, 32'd5, 0, '0, '0, 0);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req_ready", 64'(bus.req_ready), 64'd1);
        check("arst_res_valid", 64'(bus.res_valid), 64'd0);
        check("arst_result", 64'(bus.result), 64'd0);
`ifdef MULDIV_REM_EN
        check("arst_rem", 64'(bus.rem), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("arst_still_idle", 64'(bus.res_valid), 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
